// File: rtl/bullet_target_hit.sv
// -----------------------------------------------------------------------------
// bullet_target_hit
//
// This module sits downstream of the bullet stage and tests the bullet box
// against one target box once per frame. It tracks the target's hit points,
// the post-hit flash window, the death and respawn timing, and a kill score.
//
// Optional feature macro: TARGET_FLASH_EN
//   defined   : a non-lethal hit puts the target in FLASH for FLASH_FRAMES
//               frames. During FLASH the target cannot be hit.
//   undefined : a non-lethal hit leaves the target ALIVE and target_flash is
//               tied to 0. Lethal hits and DEAD behave the same in both builds.
//
// Parameters:
//   TARGET_HP      hit points on spawn and respawn (1..15)
//   FLASH_FRAMES   frames of post-hit flash and invulnerability (>=1)
//   RESPAWN_FRAMES frames the target stays dead before it respawns (>=1)
//
// Ports:
//   frame_clk      frame clock; the only clock
//   Reset          synchronous, active-high reset
//   BulletX/Y/S    bullet centre and half-size
//   bullet_on      high while the bullet is in flight
//   TargetX/Y/S    target centre and half-size
//   target_alive   target is drawn and can be hit
//   target_flash   target is in its post-hit flash
//   bullet_hit     one-frame pulse for each registered hit
//   target_hp      remaining hit points
//   score          kill count; saturates at 16'hFFFF
//
// Every output is registered. A hit sampled at edge N is visible after edge N.
// -----------------------------------------------------------------------------
module bullet_target_hit #(
    parameter int TARGET_HP      = 3,
    parameter int FLASH_FRAMES   = 8,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [9:0]  BulletX,
    input  logic [9:0]  BulletY,
    input  logic [9:0]  BulletS,
    input  logic        bullet_on,
    input  logic [9:0]  TargetX,
    input  logic [9:0]  TargetY,
    input  logic [9:0]  TargetS,
    output logic        target_alive,
    output logic        target_flash,
    output logic        bullet_hit,
    output logic [3:0]  target_hp,
    output logic [15:0] score
);

    // The counter must be wide enough for the longer of the two timed states.
    localparam int CNT_MAX = (FLASH_FRAMES > RESPAWN_FRAMES) ? FLASH_FRAMES : RESPAWN_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RESPAWN = CNT_W'(RESPAWN_FRAMES);
`ifdef TARGET_FLASH_EN
    localparam logic [CNT_W-1:0] CNT_FLASH   = CNT_W'(FLASH_FRAMES);
`endif
    localparam logic [3:0]       HP_INIT     = 4'(TARGET_HP);
    localparam logic [15:0]      SCORE_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_FLASH = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Overlap test. Each axis distance is an 11-bit unsigned difference,
    // always the larger value minus the smaller, so it cannot underflow.
    // Boxes whose edges touch count as overlapping (<=).
    // ------------------------------------------------------------------
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] r_sum;
    logic        overlap;

    assign dx = (BulletX >= TargetX) ? ({1'b0, BulletX} - {1'b0, TargetX})
                                     : ({1'b0, TargetX} - {1'b0, BulletX});
    assign dy = (BulletY >= TargetY) ? ({1'b0, BulletY} - {1'b0, TargetY})
                                     : ({1'b0, TargetY} - {1'b0, BulletY});
    assign r_sum   = {1'b0, BulletS} + {1'b0, TargetS};
    assign overlap = (dx <= r_sum) && (dy <= r_sum);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]       hp_q,     hp_d;
    logic [15:0]      score_q,  score_d;
    logic             armed_q,  armed_d;
    logic             alive_q,  alive_d;
    logic             hit_q,    hit_d;
`ifdef TARGET_FLASH_EN
    logic             flash_q,  flash_d;
`endif

    // A hit is taken only while ALIVE, with an armed bullet in flight that
    // overlaps the target. armed allows one hit per bullet flight.
    logic hit_take;
    assign hit_take = bullet_on && armed_q && overlap && (state_q == ST_ALIVE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        score_d = score_q;
        armed_d = armed_q;
        alive_d = alive_q;
        hit_d   = 1'b0;
`ifdef TARGET_FLASH_EN
        flash_d = flash_q;
`endif

        // Re-arm whenever the bullet is out of flight. A hit needs
        // bullet_on=1, so the set and clear conditions never coincide.
        if (!bullet_on) begin
            armed_d = 1'b1;
        end else if (hit_take) begin
            armed_d = 1'b0;
        end

        case (state_q)
            ST_ALIVE: begin
                if (hit_take) begin
                    hit_d = 1'b1;
                    hp_d  = hp_q - 4'd1;
                    if (hp_q == 4'd1) begin
                        // Lethal hit: go dead, start the respawn timer and count the kill.
                        state_d = ST_DEAD;
                        cnt_d   = CNT_RESPAWN;
                        alive_d = 1'b0;
                        hp_d    = 4'd0;
`ifdef TARGET_FLASH_EN
                        flash_d = 1'b0;
`endif
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + 16'd1;
                        end
                    end else begin
`ifdef TARGET_FLASH_EN
                        state_d = ST_FLASH;
                        cnt_d   = CNT_FLASH;
                        flash_d = 1'b1;
`endif
                    end
                end
            end

`ifdef TARGET_FLASH_EN
            ST_FLASH: begin
                // The counter is loaded with FLASH_FRAMES. Leaving on the
                // count==1 edge makes the flash last exactly FLASH_FRAMES frames.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_ALIVE;
                    flash_d = 1'b0;
                end
                cnt_d = cnt_q - CNT_ONE;
            end
`endif

            ST_DEAD: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_ALIVE;
                    alive_d = 1'b1;
                    hp_d    = HP_INIT;
                end
                cnt_d = cnt_q - CNT_ONE;
            end

            default: begin
                state_d = ST_ALIVE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_ALIVE;
            cnt_q   <= '0;
            hp_q    <= HP_INIT;
            score_q <= 16'd0;
            armed_q <= 1'b1;
            alive_q <= 1'b1;
            hit_q   <= 1'b0;
`ifdef TARGET_FLASH_EN
            flash_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            score_q <= score_d;
            armed_q <= armed_d;
            alive_q <= alive_d;
            hit_q   <= hit_d;
`ifdef TARGET_FLASH_EN
            flash_q <= flash_d;
`endif
        end
    end

    assign target_alive = alive_q;
    assign bullet_hit   = hit_q;
    assign target_hp    = hp_q;
    assign score        = score_q;
`ifdef TARGET_FLASH_EN
    assign target_flash = flash_q;
`else
    assign target_flash = 1'b0;
`endif

endmodule

// File: tb/tb_bullet_target_hit.sv
// -----------------------------------------------------------------------------
// tb_bullet_target_hit
//
// Each frame the bench drives stimulus and steps a reference model. It pushes
// the model's expected outputs {alive, flash, hit, hp, score} into exp_q, then
// pops that entry and compares it with the DUT one time unit after the clock
// edge. Directed checks at known points in the scenario go through the same
// check task.
// -----------------------------------------------------------------------------
module tb_bullet_target_hit;

    localparam int TARGET_HP      = 3;
    localparam int FLASH_FRAMES   = 8;
    localparam int RESPAWN_FRAMES = 60;
`ifdef TARGET_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  bx, by, bs, tx, ty, ts;
    logic        bon;
    logic        target_alive, target_flash, bullet_hit;
    logic [3:0]  target_hp;
    logic [15:0] score;

    int checks   = 0;
    int failures = 0;

    logic [22:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bullet_target_hit #(
        .TARGET_HP      (TARGET_HP),
        .FLASH_FRAMES   (FLASH_FRAMES),
        .RESPAWN_FRAMES (RESPAWN_FRAMES)
    ) dut (
        .frame_clk    (clk),
        .Reset        (rst),
        .BulletX      (bx),
        .BulletY      (by),
        .BulletS      (bs),
        .bullet_on    (bon),
        .TargetX      (tx),
        .TargetY      (ty),
        .TargetS      (ts),
        .target_alive (target_alive),
        .target_flash (target_flash),
        .bullet_hit   (bullet_hit),
        .target_hp    (target_hp),
        .score        (score)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_st: 0 alive, 1 flash, 2 dead
    int m_st, m_cnt, m_hp, m_score;
    bit m_armed, m_hit;

    task automatic model_step();
        int dx, dy, rr;
        bit ovl, take;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_hp = TARGET_HP; m_score = 0; m_armed = 1; m_hit = 0;
        end else begin
            dx   = (int'(bx) > int'(tx)) ? int'(bx) - int'(tx) : int'(tx) - int'(bx);
            dy   = (int'(by) > int'(ty)) ? int'(by) - int'(ty) : int'(ty) - int'(by);
            rr   = int'(bs) + int'(ts);
            ovl  = (dx <= rr) && (dy <= rr);
            take = bon && m_armed && ovl && (m_st == 0);
            m_hit = take;
            if (!bon) m_armed = 1;
            else if (take) m_armed = 0;
            case (m_st)
                0: if (take) begin
                    m_hp--;
                    if (m_hp == 0) begin
                        m_st = 2; m_cnt = RESPAWN_FRAMES;
                        if (m_score < 65535) m_score++;
                    end else if (FLASH_ON) begin
                        m_st = 1; m_cnt = FLASH_FRAMES;
                    end
                end
                1: begin
                    if (m_cnt == 1) m_st = 0;
                    m_cnt--;
                end
                default: begin
                    if (m_cnt == 1) begin m_st = 0; m_hp = TARGET_HP; end
                    m_cnt--;
                end
            endcase
        end
        exp_q.push_back({(m_st != 2), (m_st == 1), m_hit, 4'(m_hp), 16'(m_score)});
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        logic [22:0] e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("cycle", {9'd0, target_alive, target_flash, bullet_hit, target_hp, score}, {9'd0, e});
    endtask

    task automatic kill_target();
        for (int k = 0; k < TARGET_HP; k++) begin
            bon = 1'b0; tick();
            bon = 1'b1; tick();
            check("kill_seq_hit", 32'(bullet_hit), 32'd1);
            bon = 1'b0;
            for (int j = 0; j <= FLASH_FRAMES; j++) tick();
        end
    endtask

    int flash_cnt, dead_cnt, hit_cnt;

    initial begin
        rst = 1'b1; bon = 1'b0;
        bx = 10'd320; by = 10'd200; bs = 10'd4;
        tx = 10'd300; ty = 10'd200; ts = 10'd8;
        tick(); tick();
        check("reset_state", {9'd0, target_alive, target_flash, bullet_hit, target_hp, score},
              {9'd0, 1'b1, 1'b0, 1'b0, 4'd3, 16'd0});

        // dx = 20 > 12: no hit
        rst = 1'b0; bon = 1'b1;
        tick(); tick();
        check("miss_hp", 32'(target_hp), 32'd3);
        check("miss_pulse", 32'(bullet_hit), 32'd0);

        // dx = 12 == r: edges touch, so this is a hit
        bx = 10'd312;
        tick();
        check("hit_pulse", 32'(bullet_hit), 32'd1);
        check("hit_hp", 32'(target_hp), 32'd2);
        check("hit_flash", 32'(target_flash), 32'(FLASH_ON));

        // bullet held overlapping: no second hit, flash runs its course
        flash_cnt = int'(target_flash);
        for (int i = 0; i < 11; i++) begin
            tick();
            if (i == 0) check("no_double_pulse", 32'(bullet_hit), 32'd0);
            flash_cnt += int'(target_flash);
        end
        check("flash_len", 32'(flash_cnt), FLASH_ON ? 32'd8 : 32'd0);
        check("held_hp", 32'(target_hp), 32'd2);

        // re-arm: bullet_on falls then rises
        bon = 1'b0; tick();
        bon = 1'b1; tick();
        check("rearm_hit", 32'(bullet_hit), 32'd1);
        check("rearm_hp", 32'(target_hp), 32'd1);

        // let flash finish, then the lethal hit
        bon = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bon = 1'b1; tick();
        check("kill_hit", 32'(bullet_hit), 32'd1);
        check("kill_hp", 32'(target_hp), 32'd0);
        check("kill_alive", 32'(target_alive), 32'd0);
        check("kill_score", 32'(score), 32'd1);

        // dead period with overlapping bullet toggling
        dead_cnt = 1; hit_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            bon = (i < 58) ? 1'(i % 2) : 1'b0;
            tick();
            if (!target_alive) dead_cnt++;
            if (bullet_hit) hit_cnt++;
        end
        check("dead_len", 32'(dead_cnt), 32'(RESPAWN_FRAMES));
        check("dead_hits", 32'(hit_cnt), 32'd0);
        check("respawn_hp", 32'(target_hp), 32'd3);
        check("respawn_alive", 32'(target_alive), 32'd1);

        // hit, re-arm during flash; overlap must be ignored while flashing
        bon = 1'b1; tick();
        check("second_life_hit", 32'(target_hp), 32'd2);
        bon = 1'b0; tick();
        bon = 1'b1; tick(); tick(); tick();
        check("flash_ignore_hp", 32'(target_hp), FLASH_ON ? 32'd2 : 32'd1);
        check("flash_mid", 32'(target_flash), 32'(FLASH_ON));

        // reset in the middle of the flash window (counter at 4)
        rst = 1'b1; tick();
        check("reset_mid", {9'd0, target_alive, target_flash, bullet_hit, target_hp, score},
              {9'd0, 1'b1, 1'b0, 1'b0, 4'd3, 16'd0});
        rst = 1'b0; bon = 1'b0; tick();

        // score saturation: preset near the top
        force dut.score_q = 16'hFFFE;
        #1;
        release dut.score_q;
        m_score = 16'hFFFE;
        kill_target();
        check("sat_first", 32'(score), 32'hFFFF);
        bon = 1'b0;
        for (int i = 0; i < RESPAWN_FRAMES; i++) tick();
        kill_target();
        check("sat_hold", 32'(score), 32'hFFFF);
        check("sat_dead", 32'(target_alive), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
